// File: rtl/fetch_queue_if.sv
// Fetch-side bundle between the prefetch queue, the synchronous program memory
// and the decoder. The slave modport is the fetch queue itself.
interface fetch_queue_if #(
  parameter int PC_WIDTH   = 12,
  parameter int PMEM_WIDTH = 16,
  parameter int DEPTH      = 4
) ();

  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic [PC_WIDTH-1:0]   in_branch_pc;
  logic                  in_set_pc;
  logic                  in_flush;
  logic                  in_stall;
  logic [PMEM_WIDTH-1:0] in_instr;
  logic [PC_WIDTH-1:0]   out_pmem_addr;
  logic [PMEM_WIDTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]   out_pc;
  logic                  out_valid;
  logic [CNT_WIDTH-1:0]  out_count;

  modport slave (
    input  in_branch_pc,
    input  in_set_pc,
    input  in_flush,
    input  in_stall,
    input  in_instr,
    output out_pmem_addr,
    output out_instr,
    output out_pc,
    output out_valid,
    output out_count
  );

  modport master (
    output in_branch_pc,
    output in_set_pc,
    output in_flush,
    output in_stall,
    output in_instr,
    input  out_pmem_addr,
    input  out_instr,
    input  out_pc,
    input  out_valid,
    input  out_count
  );

endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch unit: one PMEM read per cycle into a DEPTH-entry prefetch
// queue of {instr, pc}, drained by the decoder under a stall handshake.
module fetch_queue #(
  parameter int                  PC_WIDTH     = 12,
  parameter int                  PMEM_WIDTH   = 16,
  parameter int                  PC_INCREMENT = 2,
  parameter int                  DEPTH        = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [PC_WIDTH-1:0]  PC_STEP   = PC_WIDTH'(PC_INCREMENT);
  localparam logic [CNT_WIDTH:0]   DEPTH_EXT = (CNT_WIDTH + 1)'(DEPTH);

  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  req_valid_q;
  logic [PC_WIDTH-1:0]   req_pc_q;

  logic [PMEM_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem    [DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [CNT_WIDTH-1:0]  count;

  logic                  redirect;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [CNT_WIDTH:0]    occupancy;
  logic [PC_WIDTH-1:0]   pmem_addr;

  // Queued words plus the outstanding read, after this cycle's pop, must leave
  // room for one more response; that alone keeps the queue from overflowing.
  always_comb begin
    redirect  = bus.in_set_pc | bus.in_flush;
    pop       = (count != '0) & ~bus.in_stall & ~redirect;
    push      = req_valid_q & ~redirect;
    occupancy = {1'b0, count} + (CNT_WIDTH + 1)'(req_valid_q) - (CNT_WIDTH + 1)'(pop);
    issue     = bus.in_set_pc | (~bus.in_flush & (occupancy < DEPTH_EXT));
    pmem_addr = bus.in_set_pc ? bus.in_branch_pc : fetch_pc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else if (issue) begin
      fetch_pc    <= pmem_addr + PC_STEP;
      req_valid_q <= 1'b1;
      req_pc_q    <= pmem_addr;
    end else begin
      req_valid_q <= 1'b0;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end

  // Entry storage needs no reset: it is only observed through out_valid.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.in_instr;
      pc_mem[wr_ptr]    <= req_pc_q;
    end
  end

  always_comb begin
    bus.out_pmem_addr = pmem_addr;
    bus.out_valid     = (count != '0);
    bus.out_count     = count;
    bus.out_instr     = bus.out_valid ? instr_mem[rd_ptr] : '0;
    bus.out_pc        = bus.out_valid ? pc_mem[rd_ptr]    : '0;
  end

endmodule
